// File: rtl/fpu_ss_pkg.sv
// Shared types for the FPU subsystem issue path: arbiter states, counter width and core-ID type.
package fpu_ss_pkg;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned CORE_ID_W = 32;

    typedef logic [CORE_ID_W-1:0] ss_core_id_t;

endpackage

// File: rtl/fpu_ss_issue_arbiter_if.sv
// Core-side issue/result channels and subsystem-side issue/result channels of the shared FPU port.
interface fpu_ss_issue_arbiter_if #(
    parameter int unsigned NB_CORES  = 8,
    parameter int unsigned PAYLOAD_W = 128,
    parameter int unsigned RESULT_W  = 64
);
    import fpu_ss_pkg::*;

    logic [NB_CORES-1:0]           core_issue_valid_i;
    logic [NB_CORES*PAYLOAD_W-1:0] core_issue_payload_i;
    logic [NB_CORES-1:0]           core_issue_ready_o;

    logic                          ss_issue_valid_o;
    logic [PAYLOAD_W-1:0]          ss_issue_payload_o;
    ss_core_id_t                   ss_issue_core_id_o;
    logic                          ss_issue_ready_i;

    logic                          ss_result_valid_i;
    ss_core_id_t                   ss_result_core_id_i;
    logic [RESULT_W-1:0]           ss_result_payload_i;
    logic                          ss_result_ready_o;

    logic [NB_CORES-1:0]           core_result_valid_o;
    logic [RESULT_W-1:0]           core_result_payload_o;
    logic [NB_CORES-1:0]           core_result_ready_i;

    logic [NB_CORES*CNT_W-1:0]     inflight_cnt_o;

    // Arbiter side
    modport slave (
        input  core_issue_valid_i, core_issue_payload_i, ss_issue_ready_i,
               ss_result_valid_i, ss_result_core_id_i, ss_result_payload_i,
               core_result_ready_i,
        output core_issue_ready_o, ss_issue_valid_o, ss_issue_payload_o,
               ss_issue_core_id_o, ss_result_ready_o, core_result_valid_o,
               core_result_payload_o, inflight_cnt_o
    );

    // Environment side (cores + subsystem)
    modport master (
        output core_issue_valid_i, core_issue_payload_i, ss_issue_ready_i,
               ss_result_valid_i, ss_result_core_id_i, ss_result_payload_i,
               core_result_ready_i,
        input  core_issue_ready_o, ss_issue_valid_o, ss_issue_payload_o,
               ss_issue_core_id_o, ss_result_ready_o, core_result_valid_o,
               core_result_payload_o, inflight_cnt_o
    );

endinterface

// File: rtl/fpu_ss_rr_picker.sv
// Combinational round-robin pick: first set bit of eligible at or above rr_ptr, wrapping to 0.
module fpu_ss_rr_picker #(
    parameter int unsigned NB_REQ = 8,
    parameter int unsigned IDX_W  = 3
) (
    input  logic [NB_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]  rr_ptr,
    output logic [IDX_W-1:0]  winner,
    output logic              any_valid
);

    logic             any_hi;
    logic             any_lo;
    logic [IDX_W-1:0] win_hi;
    logic [IDX_W-1:0] win_lo;

    // Descending scan so the lowest matching index in each half wins
    always_comb begin
        any_hi = 1'b0;
        any_lo = 1'b0;
        win_hi = '0;
        win_lo = '0;
        for (int j = int'(NB_REQ) - 1; j >= 0; j--) begin
            if (eligible[j]) begin
                if (j >= int'(rr_ptr)) begin
                    any_hi = 1'b1;
                    win_hi = IDX_W'(j);
                end else begin
                    any_lo = 1'b1;
                    win_lo = IDX_W'(j);
                end
            end
        end
        winner    = any_hi ? win_hi : win_lo;
        any_valid = any_hi | any_lo;
    end

endmodule

// File: rtl/fpu_ss_issue_arbiter.sv
// Shares the fpu_ss issue port among NB_CORES cores: locked round-robin grant, per-core
// outstanding limit, and result routing back to the originating core.
module fpu_ss_issue_arbiter
    import fpu_ss_pkg::*;
#(
    parameter int unsigned NB_CORES     = 8,
    parameter int unsigned PAYLOAD_W    = 128,
    parameter int unsigned RESULT_W     = 64,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    fpu_ss_issue_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;

    arb_state_e state_q;
    arb_state_e state_d;

    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] grant_d;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cur_grant;

    logic any_eligible;
    logic issue_valid;
    logic issue_hs;
    logic res_in_range;
    logic res_ready;
    logic res_hs;

    logic [NB_CORES-1:0] eligible;
    logic [NB_CORES-1:0] res_sel;
    logic [NB_CORES-1:0] inc;
    logic [NB_CORES-1:0] dec;

    logic [NB_CORES-1:0][CNT_W-1:0] cnt_q;
    logic [NB_CORES-1:0][CNT_W-1:0] cnt_d;

    // Eligibility uses the registered count, so a freed slot is usable one cycle later
    always_comb begin
        eligible = '0;
        for (int c = 0; c < int'(NB_CORES); c++) begin
            eligible[c] = bus.core_issue_valid_i[c] && (cnt_q[c] < CNT_W'(MAX_INFLIGHT));
        end
    end

    fpu_ss_rr_picker #(
        .NB_REQ (NB_CORES),
        .IDX_W  (IDX_W)
    ) u_picker (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr_q),
        .winner    (winner),
        .any_valid (any_eligible)
    );

    // Next-state, grant lock and pointer advance
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        cur_grant   = winner;
        issue_valid = 1'b0;
        case (state_q)
            IDLE: begin
                cur_grant   = winner;
                issue_valid = any_eligible;
                if (any_eligible && !bus.ss_issue_ready_i) begin
                    state_d = LOCKED;
                    grant_d = winner;
                end
            end
            LOCKED: begin
                cur_grant   = grant_q;
                issue_valid = bus.core_issue_valid_i[grant_q];
                // Accepted, or the locked core withdrew its request
                if (!issue_valid || bus.ss_issue_ready_i) begin
                    state_d = IDLE;
                end
            end
        endcase
        if (rst_i) begin
            issue_valid = 1'b0;
        end
        issue_hs = issue_valid && bus.ss_issue_ready_i;
        if (issue_hs) begin
            rr_ptr_d = (cur_grant == IDX_W'(NB_CORES - 1)) ? '0 : cur_grant + IDX_W'(1);
        end
    end

    always_comb begin
        bus.ss_issue_valid_o   = issue_valid;
        bus.ss_issue_core_id_o = CORE_ID_W'(cur_grant);
        bus.ss_issue_payload_o = '0;
        bus.core_issue_ready_o = '0;
        for (int c = 0; c < int'(NB_CORES); c++) begin
            if (cur_grant == IDX_W'(c)) begin
                bus.ss_issue_payload_o    = bus.core_issue_payload_i[c*PAYLOAD_W +: PAYLOAD_W];
                bus.core_issue_ready_o[c] = issue_hs;
            end
        end
    end

    // Out-of-range IDs select no core and are sunk with ready high
    always_comb begin
        res_in_range = bus.ss_result_core_id_i < CORE_ID_W'(NB_CORES);
        res_sel      = '0;
        for (int c = 0; c < int'(NB_CORES); c++) begin
            res_sel[c] = bus.ss_result_core_id_i == CORE_ID_W'(c);
        end
        res_ready                 = !res_in_range || |(res_sel & bus.core_result_ready_i);
        res_hs                    = bus.ss_result_valid_i && res_ready;
        bus.ss_result_ready_o     = res_ready;
        bus.core_result_valid_o   = {NB_CORES{bus.ss_result_valid_i}} & res_sel;
        bus.core_result_payload_o = bus.ss_result_payload_i;
    end

    always_comb begin
        inc   = '0;
        dec   = '0;
        cnt_d = cnt_q;
        for (int c = 0; c < int'(NB_CORES); c++) begin
            inc[c] = issue_hs && (cur_grant == IDX_W'(c));
            dec[c] = res_hs && res_sel[c];
            if (inc[c] && !dec[c]) begin
                cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end else if (dec[c] && !inc[c] && (cnt_q[c] != '0)) begin
                cnt_d[c] = cnt_q[c] - CNT_W'(1);
            end
        end
        bus.inflight_cnt_o = cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fpu_ss_issue_arbiter.sv
// Scoreboard bench for fpu_ss_issue_arbiter: directed scenarios then random traffic, checked
// against a cycle-level behavioural model of grant, lock, limit and routing rules.
module tb_fpu_ss_issue_arbiter;

    localparam int N    = 4;
    localparam int PW   = 32;
    localparam int RW   = 16;
    localparam int MAXI = 4;
    localparam int CW   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_ss_issue_arbiter_if #(.NB_CORES(N), .PAYLOAD_W(PW), .RESULT_W(RW)) bus ();

    fpu_ss_issue_arbiter #(
        .NB_CORES     (N),
        .PAYLOAD_W    (PW),
        .RESULT_W     (RW),
        .MAX_INFLIGHT (MAXI)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        int unsigned   cyc;
        int            id;
        logic [PW-1:0] payload;
        logic          hs;
    } issue_exp_t;

    typedef struct {
        int unsigned   cyc;
        logic [N-1:0]  route;
        logic          rdy;
        logic [RW-1:0] payload;
    } res_exp_t;

    typedef struct {
        int unsigned     cyc;
        logic [N*CW-1:0] cnt;
    } cnt_exp_t;

    issue_exp_t issue_q[$];
    res_exp_t   res_q[$];
    cnt_exp_t   cnt_q[$];

    int unsigned cyc = 0;
    int errors = 0;
    int checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus for the next cycle
    logic          s_rst;
    logic [N-1:0]  s_req;
    logic [PW-1:0] s_pay [N];
    logic          s_rdy;
    logic          s_rv;
    logic [31:0]   s_rid;
    logic [RW-1:0] s_rpay;
    logic [N-1:0]  s_crdy;

    // Model state: lock owner (-1 = none), round-robin pointer, outstanding counts
    int m_owner;
    int m_ptr;
    int m_cnt [N];
    int m_win;
    bit m_hs;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic model();
        int win;
        bit v;
        bit in_rng;
        int rid;
        bit rrdy;
        logic [N-1:0] route;
        logic [N*CW-1:0] pc;
        win = -1;
        v   = 1'b0;
        if (!s_rst) begin
            if (m_owner >= 0) begin
                win = m_owner;
                v   = s_req[win];
            end else begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (win < 0 && s_req[c] && m_cnt[c] < MAXI) win = c;
                end
                v = (win >= 0);
            end
        end
        m_hs  = v && s_rdy;
        m_win = win;
        if (v) issue_q.push_back('{cyc: cyc, id: win, payload: s_pay[win], hs: m_hs});

        in_rng = (s_rid < 32'(N));
        rid    = in_rng ? int'(s_rid) : 0;
        rrdy   = in_rng ? ((s_crdy >> rid) & N'(1)) != '0 : 1'b1;
        route  = (s_rv && in_rng) ? (N'(1) << rid) : '0;
        if (s_rv) res_q.push_back('{cyc: cyc, route: route, rdy: rrdy, payload: s_rpay});

        if (s_rst) begin
            m_owner = -1;
            m_ptr   = 0;
            for (int c = 0; c < N; c++) m_cnt[c] = 0;
        end else begin
            for (int c = 0; c < N; c++) begin
                int d;
                d = m_cnt[c] + ((m_hs && win == c) ? 1 : 0)
                             - ((s_rv && in_rng && rrdy && rid == c) ? 1 : 0);
                m_cnt[c] = (d < 0) ? 0 : d;
            end
            if (m_hs) begin
                m_ptr   = (win + 1) % N;
                m_owner = -1;
            end else begin
                m_owner = v ? win : -1;
            end
        end
        for (int c = 0; c < N; c++) pc[c*CW +: CW] = CW'(m_cnt[c]);
        cnt_q.push_back('{cyc: cyc + 1, cnt: pc});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rst                     = s_rst;
        bus.core_issue_valid_i  = s_req;
        for (int c = 0; c < N; c++) bus.core_issue_payload_i[c*PW +: PW] = s_pay[c];
        bus.ss_issue_ready_i    = s_rdy;
        bus.ss_result_valid_i   = s_rv;
        bus.ss_result_core_id_i = s_rid;
        bus.ss_result_payload_i = s_rpay;
        bus.core_result_ready_i = s_crdy;
        model();
    endtask

    task automatic rand_cycle();
        int r;
        int st;
        s_rst = ($urandom_range(0, 299) == 0);
        for (int c = 0; c < N; c++) begin
            if (!s_req[c]) begin
                if ($urandom_range(0, 1) == 1) begin
                    s_req[c] = 1'b1;
                    s_pay[c] = $urandom;
                end
            end else if ($urandom_range(0, 31) == 0) begin
                s_req[c] = 1'b0;
            end
        end
        s_rdy = ($urandom_range(0, 2) != 0);
        s_rv  = ($urandom_range(0, 2) == 0);
        r = int'($urandom_range(0, 9));
        if (r == 0) begin
            s_rid = 32'hFFFF_FFFF;
        end else if (r < 3) begin
            s_rid = $urandom_range(0, 7);
        end else begin
            s_rid = $urandom_range(0, N - 1);
            st = int'($urandom_range(0, N - 1));
            for (int k = 0; k < N; k++) begin
                if (m_cnt[(st + k) % N] > 0) s_rid = 32'((st + k) % N);
            end
        end
        s_rpay = RW'($urandom);
        s_crdy = N'($urandom);
        step();
        if (m_hs) s_req[m_win] = 1'b0;
    endtask

    // Monitor: pops the expectation matching the current cycle whenever the DUT shows activity
    always @(negedge clk) begin : mon
        issue_exp_t   ie;
        res_exp_t     re;
        cnt_exp_t     ce;
        logic [N-1:0] ev;
        while (issue_q.size() > 0 && issue_q[0].cyc < cyc) begin
            ie = issue_q.pop_front();
            checks++;
            errors++;
            $display("FAIL issue_missing cyc=%0d actual=none required=core%0d", ie.cyc, ie.id);
        end
        if (bus.ss_issue_valid_o === 1'b1) begin
            if (issue_q.size() > 0 && issue_q[0].cyc == cyc) begin
                ie = issue_q.pop_front();
                ev = ie.hs ? (N'(1) << ie.id) : '0;
                chk("issue_core_id", 64'(bus.ss_issue_core_id_o), 64'(ie.id));
                chk("issue_payload", 64'(bus.ss_issue_payload_o), 64'(ie.payload));
                chk("core_issue_ready", 64'(bus.core_issue_ready_o), 64'(ev));
            end else begin
                checks++;
                errors++;
                $display("FAIL issue_unexpected cyc=%0d actual=core%0d required=none",
                         cyc, bus.ss_issue_core_id_o);
            end
        end else begin
            chk("core_issue_ready_idle", 64'(bus.core_issue_ready_o), 64'(0));
        end

        while (res_q.size() > 0 && res_q[0].cyc < cyc) begin
            re = res_q.pop_front();
            checks++;
            errors++;
            $display("FAIL result_missing cyc=%0d actual=none required=%b", re.cyc, re.route);
        end
        if (bus.ss_result_valid_i === 1'b1 && res_q.size() > 0 && res_q[0].cyc == cyc) begin
            re = res_q.pop_front();
            chk("core_result_valid", 64'(bus.core_result_valid_o), 64'(re.route));
            chk("ss_result_ready", 64'(bus.ss_result_ready_o), 64'(re.rdy));
            chk("core_result_payload", 64'(bus.core_result_payload_o), 64'(re.payload));
        end else if (bus.ss_result_valid_i !== 1'b1) begin
            chk("core_result_valid_idle", 64'(bus.core_result_valid_o), 64'(0));
        end

        while (cnt_q.size() > 0 && cnt_q[0].cyc < cyc) begin
            ce = cnt_q.pop_front();
            checks++;
            errors++;
            $display("FAIL inflight_cnt_stale cyc=%0d actual=none required=%h", ce.cyc, ce.cnt);
        end
        if (cnt_q.size() > 0 && cnt_q[0].cyc == cyc) begin
            ce = cnt_q.pop_front();
            chk("inflight_cnt", 64'(bus.inflight_cnt_o), 64'(ce.cnt));
        end
    end

    initial begin
        rst                     = 1'b1;
        bus.core_issue_valid_i  = '0;
        bus.core_issue_payload_i = '0;
        bus.ss_issue_ready_i    = 1'b0;
        bus.ss_result_valid_i   = 1'b0;
        bus.ss_result_core_id_i = '0;
        bus.ss_result_payload_i = '0;
        bus.core_result_ready_i = '0;
        s_rst  = 1'b1;
        s_req  = '0;
        for (int c = 0; c < N; c++) s_pay[c] = '0;
        s_rdy  = 1'b0;
        s_rv   = 1'b0;
        s_rid  = '0;
        s_rpay = '0;
        s_crdy = '0;
        m_owner = -1;
        m_ptr   = 0;
        m_win   = -1;
        m_hs    = 1'b0;
        for (int c = 0; c < N; c++) m_cnt[c] = 0;
        step();
        step();
        s_rst = 1'b0;

        // Basic issue from core 2, then its result
        s_req = 4'b0100; s_pay[2] = 32'h0000_00A5; s_rdy = 1'b1;
        step();
        s_req = '0;
        step();
        s_rv = 1'b1; s_rid = 32'd2; s_rpay = 16'h1234; s_crdy = 4'b0100;
        step();
        s_rv = 1'b0;
        step();

        // All cores request with ready high until every core is at its limit
        s_req = 4'hF;
        for (int c = 0; c < N; c++) s_pay[c] = 32'h100 + 32'(c);
        repeat (20) step();
        s_req = '0; s_crdy = '1; s_rv = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_rid = 32'(i % N);
            step();
        end
        s_rv = 1'b0;

        // Lock on core 1 while core 3 also requests
        s_req = 4'b1010; s_pay[1] = 32'hB1; s_pay[3] = 32'hB3; s_rdy = 1'b0;
        repeat (3) step();
        s_rdy = 1'b1;
        step();
        s_req[1] = 1'b0;
        step();
        s_req = '0;
        step();

        // Core 0 at limit: result and request in the same cycle, then issue+result at cnt=2
        s_req = 4'b0001; s_pay[0] = 32'hC0;
        repeat (4) step();
        s_rv = 1'b1; s_rid = 32'd0; s_crdy = 4'b0001;
        step();
        s_rv = 1'b0;
        step();
        s_req = '0; s_rv = 1'b1;
        repeat (2) step();
        s_req = 4'b0001;
        step();
        s_req = '0; s_rv = 1'b0;
        step();

        // Reset while locked on core 2, then core 3 is granted at once
        s_req = 4'b0100; s_pay[2] = 32'hD2; s_rdy = 1'b0;
        repeat (2) step();
        s_rst = 1'b1;
        step();
        s_rst = 1'b0; s_req = 4'b1000; s_pay[3] = 32'hD3; s_rdy = 1'b1;
        step();
        s_req = '0;
        step();

        // Out-of-range result IDs
        s_rv = 1'b1; s_rid = 32'd7; s_crdy = '0; s_rpay = 16'hBEEF;
        step();
        s_rid = 32'hFFFF_FFFF;
        step();
        s_rv = 1'b0;
        step();

        repeat (3000) rand_cycle();

        s_rst = 1'b0; s_req = '0; s_rv = 1'b0; s_rdy = 1'b0; s_crdy = '0;
        repeat (3) step();
        @(negedge clk);
        #1;
        foreach (issue_q[i]) if (issue_q[i].cyc <= cyc) begin
            checks++; errors++;
            $display("FAIL issue_unchecked cyc=%0d actual=none required=core%0d", issue_q[i].cyc, issue_q[i].id);
        end
        foreach (res_q[i]) if (res_q[i].cyc <= cyc) begin
            checks++; errors++;
            $display("FAIL result_unchecked cyc=%0d actual=none required=%b", res_q[i].cyc, res_q[i].route);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_ss_issue_arbiter.md
# fpu_ss_issue_arbiter

Shares one FPU subsystem issue port between `NB_CORES` cores. Per-core issue requests are arbitrated round-robin, with each grant locked until the downstream handshake completes. Per-core in-flight instructions are counted so no core exceeds its outstanding limit. Results from the FPU subsystem are routed back to the originating core by core ID. The block sits between the cluster cores' X-interface issue/result channels and the `fpu_ss` predecoder/input buffer.

## Interface
Parameters:
- `NB_CORES`, 8, number of requesting cores (2..32)
- `PAYLOAD_W`, 128, issue payload width (instr + rs operands + id, opaque)
- `RESULT_W`, 64, result payload width (opaque)
- `MAX_INFLIGHT`, 4, max outstanding issued-but-unreturned instructions per core (1..15)

Ports:
- `clk_i` in 1: clock; single clock domain
- `rst_i` in 1: reset; synchronous, active-high
- `core_issue_valid_i` in NB_CORES: per-core issue request
- `core_issue_payload_i` in NB_CORES*PAYLOAD_W: per-core payload; core c occupies bits [c*PAYLOAD_W +: PAYLOAD_W]
- `core_issue_ready_o` out NB_CORES: per-core issue accept
- `ss_issue_valid_o` out 1: issue request to the subsystem
- `ss_issue_payload_o` out PAYLOAD_W: payload of the granted core
- `ss_issue_core_id_o` out 32: granted core index (matches the subsystem `in_core_id` width)
- `ss_issue_ready_i` in 1: subsystem accept
- `ss_result_valid_i` in 1: result from the subsystem
- `ss_result_core_id_i` in 32: destination core of the result
- `ss_result_payload_i` in RESULT_W: result data
- `ss_result_ready_o` out 1: result accept
- `core_result_valid_o` out NB_CORES: routed result valid
- `core_result_payload_o` out RESULT_W: result data, broadcast to all cores
- `core_result_ready_i` in NB_CORES: per-core result accept
- `inflight_cnt_o` out NB_CORES*4: per-core outstanding count, for debug and perf

## Operation
- FSM states: `IDLE`, `LOCKED`.
- `IDLE`:
  - A core is eligible when `core_issue_valid_i[c]` is high and `cnt[c] < MAX_INFLIGHT`.
  - The winner is the first eligible core at or after `rr_ptr`, searching upward with wrap-around.
  - The winner is driven combinationally onto `ss_issue_*` in the same cycle.
  - On handshake (`ss_issue_valid_o & ss_issue_ready_i`) the FSM stays in `IDLE`.
  - With no handshake, the FSM moves to `LOCKED` and latches `grant_q`.
- `LOCKED`:
  - The output remains `grant_q` regardless of other requests.
  - On handshake, go to `IDLE`.
  - If the locked core drops valid (protocol violation), go to `IDLE`; nothing is issued and `cnt` is unchanged.
- `rr_ptr` updates only on an issue handshake, to `winner+1` mod NB_CORES.
- `core_issue_ready_o[c] = ss_issue_ready_i & (c == current grant) & ss_issue_valid_o`. All other ready bits are 0.
- Result routing:
  - `core_result_valid_o[ss_result_core_id_i] = ss_result_valid_i`.
  - `ss_result_ready_o = core_result_ready_i[ss_result_core_id_i]`.
  - A core ID ≥ NB_CORES gives `ss_result_ready_o = 1`; the result is dropped and no count changes.
- Counters:
  - `cnt[c]` increments on an issue handshake for c.
  - `cnt[c]` decrements on a result handshake for c.
  - Both in the same cycle for the same c leaves `cnt` unchanged.
  - Decrement at 0 saturates at 0 (no wrap); increment can never exceed MAX_INFLIGHT because of the eligibility rule.

## Timing
- Reset, synchronous on `rst_i`, affects:
  - state `IDLE`, `rr_ptr`=0, `grant_q`=0, all `cnt`=0
  - `ss_issue_valid_o`=0 and all `core_issue_ready_o`=0 in the reset cycle
  - result outputs stay combinational pass-through.
- Reset asserted mid-`LOCKED`: the grant is abandoned and counters cleared. No handshake is reported for that cycle.
- Issue path latency: 0 cycles (combinational). Arbitration decisions, lock and counts are registered.
- The payload must be stable while `LOCKED`; the block does not re-register the payload.
- An issue for core c and a result for core c can complete in the same cycle.
- A core at `MAX_INFLIGHT` becomes eligible in the cycle after its result handshake, because eligibility uses the registered count.

## Structure
- Shared `fpu_ss_pkg` entries:
  - `arb_state_e` (IDLE, LOCKED)
  - `localparam CNT_W = 4`
  - `ss_core_id_t` (32-bit) for the core-ID fields
- Sub-module `fpu_ss_rr_picker`: combinational round-robin priority pick. Inputs are the eligible vector and `rr_ptr`; outputs are the winner index and an any-valid flag. It is reused by the LSU-side result arbiter.

## Test plan
- Basic issue and return: NB_CORES=4, core 2 requests payload 0xA5 with `ss_issue_ready_i`=1.
  - Same cycle: `ss_issue_valid_o`=1, core_id=2, `core_issue_ready_o`=4'b0100.
  - `cnt[2]`=1 next cycle.
  - A result with core_id=2 and ready raises `core_result_valid_o`=4'b0100; `cnt[2]` returns to 0.
- Round-robin fairness: all 4 cores request continuously with ready=1 every cycle.
  - Grants in order 0,1,2,3,0 on consecutive cycles.
  - Stall results so each core reaches cnt=4, after which `ss_issue_valid_o`=0.
- Lock: cores 1 and 3 request with `ss_issue_ready_i`=0 for 3 cycles, then 1.
  - Grant stays at core 1 throughout (core 3 is never granted while locked).
  - Core 1 is accepted on cycle 4 and core 3 is granted on cycle 5.
- Simultaneous events:
  - Core 0 at cnt=4: result handshake for core 0 plus a core 0 request in the same cycle → no grant that cycle; grant next cycle; cnt ends at 4.
  - Core 0 at cnt=2: issue and result for core 0 in the same cycle → cnt stays 2.
- Reset mid-lock: assert `rst_i` while `LOCKED` on core 2.
  - Next cycle: state `IDLE`, all cnt=0, `rr_ptr`=0.
  - A core 3 request is then granted immediately.
- Bad result core_id 7 with NB_CORES=4 → `ss_result_ready_o`=1, all `core_result_valid_o`=0, counters unchanged.
